// File: rtl/trigger_pkg.sv
// +----------------------------------------------------------------------------+
// | trigger_pkg                                                                |
// | Shared state encoding and stage-index sizing for the trigger sequencer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package trigger_pkg;

  localparam int C_STAGE_W    = 4;
  localparam int C_MAX_STAGES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/trigger_stage_hit.sv
// +----------------------------------------------------------------------------+
// | trigger_stage_hit                                                          |
// | Edge/level pattern match of one sequencer stage against the sample stream. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module trigger_stage_hit
  import trigger_pkg::*;
#(
  parameter int SDW = 32
) (
  input  logic [SDW-1:0] prev_i,
  input  logic [SDW-1:0] cur_i,
  input  logic [SDW-1:0] cfg_or_i,
  input  logic [SDW-1:0] cfg_and_i,
  input  logic [SDW-1:0] cfg_0_0_i,
  input  logic [SDW-1:0] cfg_0_1_i,
  input  logic [SDW-1:0] cfg_1_0_i,
  input  logic [SDW-1:0] cfg_1_1_i,
  input  logic           valid_i,
  output logic           hit_o
);

  logic [SDW-1:0] w_match;
  logic           w_and_hit;
  logic           w_or_hit;

  // Each cfg_x_y enables the (previous = x, current = y) bit transition.
  assign w_match = (~prev_i & ~cur_i & cfg_0_0_i)
                 | (~prev_i &  cur_i & cfg_0_1_i)
                 | ( prev_i & ~cur_i & cfg_1_0_i)
                 | ( prev_i &  cur_i & cfg_1_1_i);

  assign w_and_hit = (&(w_match | ~cfg_and_i)) & (|cfg_and_i);
  assign w_or_hit  = |(w_match & cfg_or_i);
  assign hit_o     = valid_i & (w_and_hit | w_or_hit);

endmodule

`default_nettype wire

// File: rtl/trigger_sequencer.sv
// +----------------------------------------------------------------------------+
// | trigger_sequencer                                                          |
// | Multi-stage logic-analyser trigger; TRIGGER_SEQUENCER_TIMEOUT_EN adds      |
// | per-stage transfer timeouts. Rev 1.0                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int SDW = 32,
  parameter int NST = 4,
  parameter int CNW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NST*SDW-1:0]   cfg_or,
  input  logic [NST*SDW-1:0]   cfg_and,
  input  logic [NST*SDW-1:0]   cfg_0_0,
  input  logic [NST*SDW-1:0]   cfg_0_1,
  input  logic [NST*SDW-1:0]   cfg_1_0,
  input  logic [NST*SDW-1:0]   cfg_1_1,
  input  logic [NST*CNW-1:0]   cfg_cnt,
  input  logic [NST*CNW-1:0]   cfg_tmo,
  input  logic [3:0]           cfg_lst,
  input  logic                 ctl_arm,
  input  logic                 ctl_abort,
  input  logic                 sti_transfer,
  input  logic [SDW-1:0]       sti_tdata,
  output logic                 sts_armed,
  output logic [3:0]           sts_stage,
  output logic                 sts_trg,
  output logic                 sts_done
);

  localparam logic [C_STAGE_W-1:0] C_LAST_MAX = C_STAGE_W'(NST - 1);

  state_t                 state_q, state_d;
  logic [C_STAGE_W-1:0]   stage_q, stage_d;
  logic [CNW-1:0]         occ_q, occ_d;
  logic                   trg_q, trg_d;
  logic [SDW-1:0]         dly_tdata_q, dly_tdata_d;

  logic [C_MAX_STAGES-1:0] w_hit_all;
  logic [CNW-1:0]          w_cnt_arr [C_MAX_STAGES];
  logic [C_STAGE_W-1:0]    w_lst;
  logic                    w_cur_hit;
  logic [CNW-1:0]          w_cur_cnt;

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
  logic [CNW-1:0]          tmo_q, tmo_d;
  logic [CNW-1:0]          w_tmo_arr [C_MAX_STAGES];
  logic [CNW-1:0]          w_cur_tmo;
`else
  logic                    unused_tmo;
  assign unused_tmo = ^cfg_tmo;
`endif

  // Stage tables are padded to 16 entries so the 4-bit stage index selects directly.
  for (genvar k = 0; k < C_MAX_STAGES; k++) begin : g_stage
    if (k < NST) begin : g_used
      trigger_stage_hit #(.SDW(SDW)) u_hit (
        .prev_i    (dly_tdata_q),
        .cur_i     (sti_tdata),
        .cfg_or_i  (cfg_or [k*SDW +: SDW]),
        .cfg_and_i (cfg_and[k*SDW +: SDW]),
        .cfg_0_0_i (cfg_0_0[k*SDW +: SDW]),
        .cfg_0_1_i (cfg_0_1[k*SDW +: SDW]),
        .cfg_1_0_i (cfg_1_0[k*SDW +: SDW]),
        .cfg_1_1_i (cfg_1_1[k*SDW +: SDW]),
        .valid_i   (sti_transfer),
        .hit_o     (w_hit_all[k])
      );
      assign w_cnt_arr[k] = cfg_cnt[k*CNW +: CNW];
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      assign w_tmo_arr[k] = cfg_tmo[k*CNW +: CNW];
`endif
    end else begin : g_pad
      assign w_hit_all[k] = 1'b0;
      assign w_cnt_arr[k] = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      assign w_tmo_arr[k] = '0;
`endif
    end
  end

  assign w_lst     = (cfg_lst > C_LAST_MAX) ? C_LAST_MAX : cfg_lst;
  assign w_cur_hit = w_hit_all[stage_q];
  assign w_cur_cnt = w_cnt_arr[stage_q];
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
  assign w_cur_tmo = w_tmo_arr[stage_q];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      occ_q       <= '0;
      trg_q       <= 1'b0;
      dly_tdata_q <= '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      occ_q       <= occ_d;
      trg_q       <= trg_d;
      dly_tdata_q <= dly_tdata_d;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    occ_d       = occ_q;
    trg_d       = 1'b0;
    dly_tdata_d = sti_transfer ? sti_tdata : dly_tdata_q;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    if (ctl_abort) begin
      state_d = ST_IDLE;
      stage_d = '0;
      occ_d   = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end else if (ctl_arm) begin
      state_d = ST_ARMED;
      stage_d = '0;
      occ_d   = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end else if (state_q == ST_ARMED && sti_transfer) begin
      if (w_cur_hit && occ_q == w_cur_cnt) begin
        occ_d = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (stage_q == w_lst) begin
          state_d = ST_FIRED;
          stage_d = '0;
          trg_d   = 1'b1;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end else begin
        if (w_cur_hit && occ_q != '1) begin
          occ_d = occ_q + 1'b1;
        end
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
        // Stage 0 never times out; later stages fall back after cfg_tmo idle transfers.
        if (stage_q != '0) begin
          if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
          end
          if (w_cur_tmo != '0 && tmo_d == w_cur_tmo) begin
            stage_d = '0;
            occ_d   = '0;
            tmo_d   = '0;
          end
        end
`endif
      end
    end
  end

  assign sts_armed = (state_q == ST_ARMED);
  assign sts_done  = (state_q == ST_FIRED);
  assign sts_stage = stage_q;
  assign sts_trg   = trg_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_trigger_sequencer                                                       |
// | Scoreboard bench: reference model predicts per-cycle status outputs.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trigger_sequencer;

  localparam int SDW = 32;
  localparam int NST = 4;
  localparam int CNW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NST*SDW-1:0]  cfg_or, cfg_and, cfg_0_0, cfg_0_1, cfg_1_0, cfg_1_1;
  logic [NST*CNW-1:0]  cfg_cnt, cfg_tmo;
  logic [3:0]          cfg_lst;
  logic                ctl_arm, ctl_abort, sti_transfer;
  logic [SDW-1:0]      sti_tdata;
  logic                sts_armed, sts_trg, sts_done;
  logic [3:0]          sts_stage;

  always #5 clk = ~clk;

  trigger_sequencer #(.SDW(SDW), .NST(NST), .CNW(CNW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_or       (cfg_or),
    .cfg_and      (cfg_and),
    .cfg_0_0      (cfg_0_0),
    .cfg_0_1      (cfg_0_1),
    .cfg_1_0      (cfg_1_0),
    .cfg_1_1      (cfg_1_1),
    .cfg_cnt      (cfg_cnt),
    .cfg_tmo      (cfg_tmo),
    .cfg_lst      (cfg_lst),
    .ctl_arm      (ctl_arm),
    .ctl_abort    (ctl_abort),
    .sti_transfer (sti_transfer),
    .sti_tdata    (sti_tdata),
    .sts_armed    (sts_armed),
    .sts_stage    (sts_stage),
    .sts_trg      (sts_trg),
    .sts_done     (sts_done)
  );

  typedef struct packed {
    logic       armed;
    logic       done;
    logic [3:0] stage;
    logic       trg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: mode 0 idle, 1 waiting on stages, 2 fired.
  int             m_mode  = 0;
  int             m_stage = 0;
  int             m_hits  = 0;
  int             m_idle  = 0;
  logic [SDW-1:0] m_hist  = '0;
  logic [SDW-1:0] alpha [4];

  function automatic bit ref_hit(int k, logic [SDW-1:0] prev, logic [SDW-1:0] cur);
    bit all_ok = 1'b1, any_or = 1'b0, and_used = 1'b0, m;
    for (int i = 0; i < SDW; i++) begin
      case ({prev[i], cur[i]})
        2'b00:   m = cfg_0_0[k*SDW + i];
        2'b01:   m = cfg_0_1[k*SDW + i];
        2'b10:   m = cfg_1_0[k*SDW + i];
        default: m = cfg_1_1[k*SDW + i];
      endcase
      if (cfg_and[k*SDW + i]) begin
        and_used = 1'b1;
        if (!m) all_ok = 1'b0;
      end
      if (cfg_or[k*SDW + i] && m) any_or = 1'b1;
    end
    return (and_used && all_ok) || any_or;
  endfunction

  task automatic model_step(input bit arm, input bit abort, input bit xfer, input logic [SDW-1:0] d);
    exp_t e;
    int   last, need, limit;
    bit   fire = 1'b0, moved = 1'b0;
    last = (int'(cfg_lst) >= NST) ? NST - 1 : int'(cfg_lst);
    if (abort) begin
      m_mode = 0; m_stage = 0; m_hits = 0; m_idle = 0;
    end else if (arm) begin
      m_mode = 1; m_stage = 0; m_hits = 0; m_idle = 0;
    end else if (m_mode == 1 && xfer) begin
      need = int'(cfg_cnt[m_stage*CNW +: CNW]);
      if (ref_hit(m_stage, m_hist, d)) begin
        if (m_hits == need) begin
          moved = 1'b1; m_hits = 0; m_idle = 0;
          if (m_stage == last) begin
            m_mode = 2; m_stage = 0; fire = 1'b1;
          end else begin
            m_stage++;
          end
        end else if (m_hits < (1 << CNW) - 1) begin
          m_hits++;
        end
      end
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
      if (!moved && m_stage > 0) begin
        limit = int'(cfg_tmo[m_stage*CNW +: CNW]);
        if (m_idle < (1 << CNW) - 1) m_idle++;
        if (limit != 0 && m_idle == limit) begin
          m_stage = 0; m_hits = 0; m_idle = 0;
        end
      end
`endif
    end
    if (xfer) m_hist = d;
    e.armed = (m_mode == 1);
    e.done  = (m_mode == 2);
    e.stage = 4'(m_stage);
    e.trg   = fire;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit arm, input bit abort, input bit xfer, input logic [SDW-1:0] d);
    @(negedge clk);
    ctl_arm      = arm;
    ctl_abort    = abort;
    sti_transfer = xfer;
    sti_tdata    = d;
    model_step(arm, abort, xfer, d);
  endtask

  // Idle step: config may be changed safely right after it.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_cfg();
    cfg_or = '0; cfg_and = '0; cfg_0_0 = '0; cfg_0_1 = '0; cfg_1_0 = '0; cfg_1_1 = '0;
    cfg_cnt = '0; cfg_tmo = '0; cfg_lst = 4'd0;
  endtask

  task automatic set_stage(input int k, input logic [SDW-1:0] o, input logic [SDW-1:0] a,
                           input logic [SDW-1:0] c00, input logic [SDW-1:0] c01,
                           input logic [SDW-1:0] c10, input logic [SDW-1:0] c11,
                           input int cnt, input int tmo);
    cfg_or [k*SDW +: SDW] = o;
    cfg_and[k*SDW +: SDW] = a;
    cfg_0_0[k*SDW +: SDW] = c00;
    cfg_0_1[k*SDW +: SDW] = c01;
    cfg_1_0[k*SDW +: SDW] = c10;
    cfg_1_1[k*SDW +: SDW] = c11;
    cfg_cnt[k*CNW +: CNW] = CNW'(cnt);
    cfg_tmo[k*CNW +: CNW] = CNW'(tmo);
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({sts_armed, sts_done, sts_stage, sts_trg} !== 7'd0) begin
      n_fail++;
      $display("FAIL %s actual armed=%b done=%b stage=%0d trg=%b required all zero",
               name, sts_armed, sts_done, sts_stage, sts_trg);
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    ctl_arm = 1'b0; ctl_abort = 1'b0; sti_transfer = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_async");
    m_mode = 0; m_stage = 0; m_hits = 0; m_idle = 0; m_hist = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: status is presented every cycle, so each edge retires one prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({sts_armed, sts_done, sts_stage, sts_trg} !== e) begin
          n_fail++;
          $display("FAIL status t=%0t actual armed=%b done=%b stage=%0d trg=%b required armed=%b done=%b stage=%0d trg=%b",
                   $time, sts_armed, sts_done, sts_stage, sts_trg, e.armed, e.done, e.stage, e.trg);
        end
      end
    end
  end

  localparam logic [SDW-1:0] VA = 32'hA;
  localparam logic [SDW-1:0] VB = 32'hB;
  localparam logic [SDW-1:0] VC = 32'hC;

  initial begin
    logic [SDW-1:0] v, d;
    int             b;
    rst = 1'b1;
    ctl_arm = 1'b0; ctl_abort = 1'b0; sti_transfer = 1'b0; sti_tdata = '0;
    clear_cfg();
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Single stage, rising edge on bit 0.
    set_stage(0, 32'h1, '0, '0, 32'h1, '0, '0, 0, 0);
    step(1, 0, 0, '0);
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h1);
    idle(3);

    // Three stages matching A, B, C held for two transfers.
    clear_cfg();
    set_stage(0, '0, VA, '0, '0, '0, VA, 0, 0);
    set_stage(1, '0, VB, '0, '0, '0, VB, 0, 0);
    set_stage(2, '0, VC, '0, '0, '0, VC, 0, 0);
    cfg_lst = 4'd2;
    step(1, 0, 0, '0);
    step(0, 0, 1, VA); step(0, 0, 1, VA);
    step(0, 0, 1, VB); step(0, 0, 1, VB);
    step(0, 0, 1, VC); step(0, 0, 1, VC);
    idle(2);

    // Abort and arm together at stage 2, then reset mid-sequence.
    step(1, 0, 0, '0);
    step(0, 0, 1, VA); step(0, 0, 1, VA);
    step(0, 0, 1, VB); step(0, 0, 1, VB);
    step(1, 1, 0, '0);
    idle(1);
    step(1, 0, 0, '0);
    step(0, 0, 1, VA); step(0, 0, 1, VA);
    do_reset_mid();
    idle(2);

    // Occurrence count of 3: fires on the fourth hit only.
    clear_cfg();
    set_stage(0, 32'h1, '0, '0, 32'h1, '0, 32'h1, 3, 0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h1);
    idle(2);
    step(0, 0, 1, 32'h1);
    idle(2);
    step(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h1);
    idle(2);

    // Timeout of 5 transfers in stage 1; lst beyond NST clamps to the last stage.
    clear_cfg();
    set_stage(0, '0, VA, '0, '0, '0, VA, 0, 0);
    set_stage(1, '0, VB, '0, '0, '0, VB, 0, 5);
    set_stage(2, '0, VC, '0, '0, '0, VC, 0, 0);
    set_stage(3, '0, VA, '0, '0, '0, VA, 0, 0);
    cfg_lst = 4'd9;
    step(1, 0, 0, '0);
    step(0, 0, 1, VA); step(0, 0, 1, VA);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h0);
    idle(2);

    // Matching data with transfer low must be ignored.
    clear_cfg();
    set_stage(0, 32'h1, '0, '0, 32'h1, '0, '0, 0, 0);
    step(1, 0, 0, '0);
    step(0, 0, 1, 32'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 32'(i % 2 == 0 ? 1 : 0));
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h1);
    idle(2);

    // Randomised configurations and streams.
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 4; a++) alpha[a] = 32'($urandom_range(0, 15));
      clear_cfg();
      for (int k = 0; k < NST; k++) begin
        v = alpha[$urandom_range(0, 3)];
        b = $urandom_range(0, 3);
        case ($urandom_range(0, 2))
          0: set_stage(k, '0, v, '0, '0, '0, v, $urandom_range(0, 2), $urandom_range(0, 4));
          1: set_stage(k, '0, '1, ~v, v, ~v, v, $urandom_range(0, 2), $urandom_range(0, 4));
          default: begin
            d = 32'(1) << b;
            if ($urandom_range(0, 1) == 1)
              set_stage(k, d, '0, '0, d, '0, '0, $urandom_range(0, 2), $urandom_range(0, 4));
            else
              set_stage(k, d, '0, '0, '0, d, '0, $urandom_range(0, 2), $urandom_range(0, 4));
          end
        endcase
      end
      cfg_lst = 4'($urandom_range(0, 5));
      step(1, 0, 0, '0);
      for (int c = 0; c < 60; c++) begin
        d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : alpha[$urandom_range(0, 3)];
        step(($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 9) < 7), d);
      end
      idle(1);
    end

    idle(2);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter SDW, default 32, sample data width.
REQ-002 SHALL have parameter NST, default 4, number of sequencer stages (1..16).
REQ-003 SHALL have parameter CNW, default 16, occurrence/timeout counter width.
REQ-004 SHALL have ports, in order: clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-005 SHALL have cfg_or, cfg_and, cfg_0_0, cfg_0_1, cfg_1_0, cfg_1_1, each input NST*SDW; stage k uses slice [k*SDW +: SDW].
REQ-006 SHALL have cfg_cnt input NST*CNW (per-stage occurrence count), cfg_tmo input NST*CNW (per-stage timeout), cfg_lst input 4 (index of last used stage).
REQ-007 SHALL have ctl_arm input 1 (arm pulse), ctl_abort input 1 (abort pulse).
REQ-008 SHALL have sti_transfer input 1, sti_tdata input SDW (sample stream).
REQ-009 SHALL have outputs sts_armed 1, sts_stage 4 (current stage), sts_trg 1 (trigger pulse), sts_done 1 (fired, awaiting re-arm).

Function
REQ-010 SHALL keep history register dly_tdata, loaded with sti_tdata on every sti_transfer, including while IDLE.
REQ-011 Per-bit match for stage k SHALL be OR of the four (previous,current) bit-pair terms, each masked by the corresponding cfg_x_y slice.
REQ-012 Stage hit SHALL be (AND over bits of match|~cfg_and, qualified by cfg_and nonzero) OR (any bit of match&cfg_or); evaluated only on sti_transfer cycles.
REQ-013 FSM states SHALL be IDLE, ARMED, FIRED; reset state IDLE.
REQ-014 IDLE/FIRED -> ARMED on ctl_arm: stage=0, occurrence counter=0, timeout counter=0.
REQ-015 In ARMED, each hit of current stage k SHALL increment occurrence counter; when counter equals cfg_cnt[k] at a hit (cfg_cnt=0 means first hit), stage advances, counters clear.
REQ-016 Advancing from stage k==cfg_lst SHALL enter FIRED and assert sts_trg for exactly one clk on the following cycle (one-cycle latency from the qualifying transfer).
REQ-017 cfg_lst >= NST SHALL be treated as NST-1.
REQ-018 ctl_abort SHALL force IDLE from any state next cycle; abort and arm together: abort wins.
REQ-019 ctl_arm while ARMED SHALL restart at stage 0 with counters cleared.
REQ-020 Occurrence counter SHALL saturate at all-ones, never wrap.
REQ-021 sts_armed=1 only in ARMED; sts_done=1 only in FIRED; sts_stage reflects current stage (0 outside ARMED).
REQ-022 Sample data with sti_transfer low SHALL never affect state, counters or history.

Reset
REQ-023 On rst: state IDLE, dly_tdata=0, counters=0, sts_trg=0, sts_armed=0, sts_done=0, sts_stage=0; rst mid-sequence SHALL discard all progress.

Configuration
REQ-024 Macro TRIGGER_SEQUENCER_TIMEOUT_EN: when defined, in stage k>0 a timeout counter counts transfers without advance; reaching cfg_tmo[k] (nonzero) SHALL return to stage 0, counters cleared; cfg_tmo=0 disables for that stage.
REQ-025 Without the macro, cfg_tmo SHALL be ignored, no timeout logic synthesised, ports retained.

Structure
REQ-026 Shared package trigger_pkg SHALL hold FSM state encoding constants and stage-index width constant.
REQ-027 Per-stage match/hit logic SHALL be a sub-module trigger_stage_hit, instantiated NST times in a generate loop; history register shared in top.

Verification
REQ-028 NST=4, cfg_lst=0, stage0 cfg_0_1=0x1, cfg_or=0x1; arm; data 0->1 on bit0 -> sts_trg one cycle after the rising transfer, sts_done=1.
REQ-029 cfg_lst=2, stages match 0xA, 0xB, 0xC via cfg_1_1/cfg_and full mask; send A,A,B,B,C,C -> sts_stage 0,1,2, sts_trg after second C.
REQ-030 stage0 cfg_cnt=3; four hits -> fires on 4th hit only; 3 hits -> stays stage 0.
REQ-031 ctl_arm and ctl_abort same cycle while ARMED at stage 2 -> IDLE, sts_stage=0; rst asserted mid-sequence -> all outputs 0 same cycle.
REQ-032 With TRIGGER_SEQUENCER_TIMEOUT_EN, cfg_tmo[1]=5, reach stage 1, send 5 non-matching transfers -> sts_stage returns 0; without macro -> stays 1.
REQ-033 Hold sti_transfer low with matching data for 10 cycles -> no stage change, no sts_trg.
